// File: rtl/sram_like_pkg.sv
// Shared definitions for the SRAM-like channel arbiter.
//   - SZ_BYTE / SZ_HALF / SZ_WORD : transfer size encodings carried on m_size / s_size
//   - ARB_FIXED / ARB_RR          : arbitration mode selectors for the ARB_MODE parameter
//   - clog2()                     : ceiling log2, never smaller than 1, for sizing IDs and pointers
package sram_like_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Ceiling log2 with a floor of 1 so that a single-bit ID or pointer is
    // still produced for tiny configurations.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < 32'(value)) begin
                result = i + 1;
            end
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sram_like_id_fifo.sv
// In-order channel-ID FIFO. Every request accepted by the slave pushes the ID
// of the channel that issued it; every slave response pops the oldest ID so
// the response can be routed back to its owner.
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset (clears pointers and count)
//   push, din     : enqueue din (ignored when full unless a pop happens in the same cycle)
//   pop           : dequeue the head entry (ignored when empty)
//   head          : oldest stored ID
//   full, empty   : occupancy flags
//   count         : number of stored entries (0..DEPTH)
module sram_like_id_fifo
    import sram_like_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1,
    parameter int CNT_W = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = CNT_W - 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;

    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign empty_s = (count_r == CNT_W'(0));

    // A push into a full FIFO is only legal when an entry leaves in the same cycle.
    assign pop_s  = pop & ~empty_s;
    assign push_s = push & (~full_s | pop_s);

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= WIDTH'(0);
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;

endmodule

// File: rtl/sram_like_arbiter.sv
// N-channel SRAM-like arbiter. Merges several SRAM-like master ports
// (req / addr_ok / data_ok handshake) onto a single SRAM-like slave port.
// Several requests may be in flight; the slave answers in order and a
// channel-ID FIFO routes each response back to the channel that issued it.
// Ports:
//   clk, resetn                           : clock, asynchronous active-low reset
//   m_req/m_wr/m_size/m_wstrb/m_addr/m_wdata : packed per-channel request buses (channel i at slice i)
//   m_addr_ok                             : one-hot, request of that channel accepted this cycle
//   m_data_ok                             : one-hot, response for that channel this cycle
//   m_rdata                               : slave read data, broadcast to all channels
//   s_req/s_wr/s_size/s_wstrb/s_addr/s_wdata : request of the granted channel towards the slave
//   s_addr_ok, s_data_ok, s_rdata         : slave handshake and read data
//   outstanding_cnt                       : accepted-but-unanswered requests
//   proto_err                             : sticky, a response arrived with nothing outstanding
module sram_like_arbiter
    import sram_like_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ARB_MODE        = 0
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NUM_CH-1:0]              m_req,
    input  logic [NUM_CH-1:0]              m_wr,
    input  logic [2*NUM_CH-1:0]            m_size,
    input  logic [(DATA_W/8)*NUM_CH-1:0]   m_wstrb,
    input  logic [ADDR_W*NUM_CH-1:0]       m_addr,
    input  logic [DATA_W*NUM_CH-1:0]       m_wdata,
    output logic [NUM_CH-1:0]              m_addr_ok,
    output logic [NUM_CH-1:0]              m_data_ok,
    output logic [DATA_W-1:0]              m_rdata,
    output logic                           s_req,
    output logic                           s_wr,
    output logic [1:0]                     s_size,
    output logic [DATA_W/8-1:0]            s_wstrb,
    output logic [ADDR_W-1:0]              s_addr,
    output logic [DATA_W-1:0]              s_wdata,
    input  logic                           s_addr_ok,
    input  logic                           s_data_ok,
    input  logic [DATA_W-1:0]              s_rdata,
    output logic [clog2(MAX_OUTSTANDING):0] outstanding_cnt,
    output logic                           proto_err
);

    localparam int ID_W   = clog2(NUM_CH);
    localparam int CNT_W  = clog2(MAX_OUTSTANDING) + 1;
    localparam int STRB_W = DATA_W / 8;

    logic [ID_W-1:0]  grant_s;
    logic [ID_W-1:0]  rr_idx_s;
    logic             found_s;
    logic [ID_W-1:0]  lock_id_r;
    logic             lock_valid_r;
    logic [ID_W-1:0]  rr_ptr_r;
    logic             proto_err_r;
    logic [ID_W-1:0]  head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             s_req_raw_s;
    logic             accept_s;
    logic             resp_s;

    // Grant selection: a stalled request keeps its grant; otherwise fixed
    // priority (highest index) or round-robin starting after the last winner.
    always_comb begin
        grant_s  = ID_W'(0);
        rr_idx_s = ID_W'(0);
        found_s  = 1'b0;
        if (lock_valid_r) begin
            grant_s = lock_id_r;
        end else if (ARB_MODE == ARB_RR) begin
            for (int i = 1; i <= NUM_CH; i++) begin
                rr_idx_s = ID_W'((int'(rr_ptr_r) + i) % NUM_CH);
                if (!found_s && m_req[rr_idx_s]) begin
                    grant_s = rr_idx_s;
                    found_s = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_req[i]) begin
                    grant_s = ID_W'(i);
                end else begin
                    grant_s = grant_s;
                end
            end
        end
    end

    // A locked request is held on the bus even if its master has dropped
    // m_req; a new request is never started while the ID FIFO is full.
    assign s_req_raw_s = (m_req[grant_s] & ~fifo_full_s) | lock_valid_r;
    assign accept_s    = s_req_raw_s & s_addr_ok & resetn;
    assign resp_s      = s_data_ok & ~fifo_empty_s & resetn;

    // Request mux, handshake strobes and response routing; everything is forced low in reset.
    always_comb begin
        s_req     = 1'b0;
        s_wr      = 1'b0;
        s_size    = 2'd0;
        s_wstrb   = STRB_W'(0);
        s_addr    = ADDR_W'(0);
        s_wdata   = DATA_W'(0);
        m_rdata   = DATA_W'(0);
        m_addr_ok = NUM_CH'(0);
        m_data_ok = NUM_CH'(0);
        if (resetn) begin
            s_req   = s_req_raw_s;
            s_wr    = m_wr[grant_s];
            s_size  = m_size[int'(grant_s)*2 +: 2];
            s_wstrb = m_wstrb[int'(grant_s)*STRB_W +: STRB_W];
            s_addr  = m_addr[int'(grant_s)*ADDR_W +: ADDR_W];
            s_wdata = m_wdata[int'(grant_s)*DATA_W +: DATA_W];
            m_rdata = s_rdata;
            if (accept_s) begin
                m_addr_ok[grant_s] = 1'b1;
            end else begin
                m_addr_ok = NUM_CH'(0);
            end
            if (resp_s) begin
                m_data_ok[head_s] = 1'b1;
            end else begin
                m_data_ok = NUM_CH'(0);
            end
        end else begin
            s_req = 1'b0;
        end
    end

    // Grant lock, round-robin pointer and sticky protocol error flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_valid_r <= 1'b0;
            lock_id_r    <= ID_W'(0);
            rr_ptr_r     <= ID_W'(NUM_CH - 1);
            proto_err_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                lock_valid_r <= 1'b0;
            end else if (lock_valid_r && !m_req[lock_id_r]) begin
                // Master abandoned a stalled request: release after this cycle.
                lock_valid_r <= 1'b0;
            end else if (s_req_raw_s && !fifo_full_s) begin
                lock_valid_r <= 1'b1;
                lock_id_r    <= grant_s;
            end else begin
                lock_valid_r <= lock_valid_r;
            end
            if ((ARB_MODE == ARB_RR) && accept_s) begin
                rr_ptr_r <= grant_s;
            end
            if (s_data_ok && fifo_empty_s) begin
                proto_err_r <= 1'b1;
            end
        end
    end

    sram_like_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_W),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept_s),
        .pop    (resp_s),
        .din    (grant_s),
        .head   (head_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s),
        .count  (fifo_count_s)
    );

    assign outstanding_cnt = fifo_count_s;
    assign proto_err       = proto_err_r;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter. Two instances share all inputs:
// dut_fix (fixed priority) and dut_rr (round-robin). Inputs change 1 time
// unit after a rising edge; outputs are sampled 1 time unit later.
module tb_sram_like_arbiter;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0004;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  m_req;
    logic [1:0]  m_wr;
    logic [3:0]  m_size;
    logic [7:0]  m_wstrb;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic        s_addr_ok;
    logic        s_data_ok;
    logic [31:0] s_rdata;

    logic [1:0]  f_addr_ok, f_data_ok, r_addr_ok, r_data_ok;
    logic [31:0] f_rdata, r_rdata, f_s_addr, r_s_addr, f_s_wdata, r_s_wdata;
    logic        f_s_req, r_s_req, f_s_wr, r_s_wr, f_perr, r_perr;
    logic [1:0]  f_s_size, r_s_size;
    logic [3:0]  f_s_wstrb, r_s_wstrb;
    logic [2:0]  f_cnt, r_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4), .ARB_MODE(0)) dut_fix (
        .clk(clk), .resetn(resetn), .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(f_addr_ok), .m_data_ok(f_data_ok), .m_rdata(f_rdata),
        .s_req(f_s_req), .s_wr(f_s_wr), .s_size(f_s_size), .s_wstrb(f_s_wstrb), .s_addr(f_s_addr),
        .s_wdata(f_s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .outstanding_cnt(f_cnt), .proto_err(f_perr)
    );

    sram_like_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4), .ARB_MODE(1)) dut_rr (
        .clk(clk), .resetn(resetn), .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(r_addr_ok), .m_data_ok(r_data_ok), .m_rdata(r_rdata),
        .s_req(r_s_req), .s_wr(r_s_wr), .s_size(r_s_size), .s_wstrb(r_s_wstrb), .s_addr(r_s_addr),
        .s_wdata(r_s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .outstanding_cnt(r_cnt), .proto_err(r_perr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_req = 2'b00; m_wr = 2'b00; m_size = 4'h0; m_wstrb = 8'h00;
        m_addr = {A1, A0}; m_wdata = 64'd0;
        s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'd0;
    endtask

    task automatic test_reset();
        clear_inputs();
        m_req = 2'b11; s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'hFFFF_FFFF;
        #2;
        tests_run++; if (f_s_req !== 1'b0 || r_s_req !== 1'b0) begin tests_failed++; $display("FAIL reset_s_req: got %b/%b, expected 0/0", f_s_req, r_s_req); end
        tests_run++; if (f_addr_ok !== 2'b00 || f_data_ok !== 2'b00) begin tests_failed++; $display("FAIL reset_oks: got %b/%b, expected 00/00", f_addr_ok, f_data_ok); end
        tests_run++; if (f_rdata !== 32'd0 || f_cnt !== 3'd0 || f_perr !== 1'b0) begin tests_failed++; $display("FAIL reset_regs: rdata=%h cnt=%0d perr=%b, expected 0/0/0", f_rdata, f_cnt, f_perr); end
        clear_inputs();
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        m_req = 2'b01; m_size = {2'd2, 2'd2}; s_addr_ok = 1'b1; #1;
        tests_run++; if (f_addr_ok !== 2'b01 || r_addr_ok !== 2'b01) begin tests_failed++; $display("FAIL single_addr_ok: got %b/%b, expected 01/01", f_addr_ok, r_addr_ok); end
        tests_run++; if (f_s_addr !== A0 || f_s_wr !== 1'b0) begin tests_failed++; $display("FAIL single_s_addr: got %h wr=%b, expected %h wr=0", f_s_addr, f_s_wr, A0); end
        tick(); m_req = 2'b00; s_addr_ok = 1'b0; #1;
        tests_run++; if (f_cnt !== 3'd1) begin tests_failed++; $display("FAIL single_cnt1: got %0d, expected 1", f_cnt); end
        tick(); s_data_ok = 1'b1; s_rdata = 32'hDEADBEEF; #1;
        tests_run++; if (f_data_ok !== 2'b01 || f_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL single_data_ok: got %b %h, expected 01 deadbeef", f_data_ok, f_rdata); end
        tick(); s_data_ok = 1'b0; #1;
        tests_run++; if (f_cnt !== 3'd0) begin tests_failed++; $display("FAIL single_cnt0: got %0d, expected 0", f_cnt); end
        clear_inputs();
    endtask

    task automatic test_write();
        m_req = 2'b10; m_wr = 2'b10; m_size = {2'd1, 2'd0}; m_wstrb = 8'b1100_0001;
        m_wdata = {32'hCAFE_0000, 32'h1111_1111}; s_addr_ok = 1'b1; #1;
        tests_run++; if (f_s_wr !== 1'b1 || f_s_size !== 2'd1 || f_s_wstrb !== 4'b1100) begin tests_failed++; $display("FAIL write_ctrl: got wr=%b size=%0d strb=%b, expected 1/1/1100", f_s_wr, f_s_size, f_s_wstrb); end
        tests_run++; if (f_s_addr !== A1 || f_s_wdata !== 32'hCAFE_0000 || f_addr_ok !== 2'b10) begin tests_failed++; $display("FAIL write_payload: got %h %h ok=%b, expected %h cafe0000 10", f_s_addr, f_s_wdata, f_addr_ok, A1); end
        tick(); clear_inputs(); s_data_ok = 1'b1; #1;
        tests_run++; if (f_data_ok !== 2'b10) begin tests_failed++; $display("FAIL write_data_ok: got %b, expected 10", f_data_ok); end
        tick(); clear_inputs(); #1;
        tests_run++; if (f_cnt !== 3'd0) begin tests_failed++; $display("FAIL write_cnt0: got %0d, expected 0", f_cnt); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_seq [4];
        exp_seq[0] = 2'b10; exp_seq[1] = 2'b01; exp_seq[2] = 2'b10; exp_seq[3] = 2'b01;
        // ch1 starts one cycle early, then both request continuously.
        m_req = 2'b10; s_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++; if (r_addr_ok !== exp_seq[i]) begin tests_failed++; $display("FAIL rr_grant%0d: got %b, expected %b", i, r_addr_ok, exp_seq[i]); end
            tick(); m_req = 2'b11;
        end
        #1;
        tests_run++; if (r_s_req !== 1'b0 || r_cnt !== 3'd4) begin tests_failed++; $display("FAIL rr_full: got s_req=%b cnt=%0d, expected 0/4", r_s_req, r_cnt); end
        tick(); m_req = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++; if (r_data_ok !== exp_seq[i]) begin tests_failed++; $display("FAIL rr_resp%0d: got %b, expected %b", i, r_data_ok, exp_seq[i]); end
            tests_run++; if (f_data_ok !== 2'b10) begin tests_failed++; $display("FAIL fix_resp%0d: got %b, expected 10", i, f_data_ok); end
            tick();
        end
        clear_inputs(); #1;
        tests_run++; if (r_cnt !== 3'd0) begin tests_failed++; $display("FAIL rr_cnt0: got %0d, expected 0", r_cnt); end
    endtask

    task automatic test_fixed_priority();
        m_req = 2'b11; s_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++; if (f_addr_ok !== 2'b10) begin tests_failed++; $display("FAIL fix_grant%0d: got %b, expected 10", i, f_addr_ok); end
            tick();
        end
        #1;
        tests_run++; if (f_s_req !== 1'b0 || f_addr_ok !== 2'b00) begin tests_failed++; $display("FAIL fix_blocked: got s_req=%b ok=%b, expected 0/00", f_s_req, f_addr_ok); end
        tick(); m_req = 2'b01; s_data_ok = 1'b1; #1;
        tests_run++; if (f_data_ok !== 2'b10 || f_addr_ok !== 2'b00) begin tests_failed++; $display("FAIL fix_pop_full: got data_ok=%b addr_ok=%b, expected 10/00", f_data_ok, f_addr_ok); end
        tick(); #1;
        tests_run++; if (f_addr_ok !== 2'b01 || f_data_ok !== 2'b10) begin tests_failed++; $display("FAIL fix_ch0_after: got addr_ok=%b data_ok=%b, expected 01/10", f_addr_ok, f_data_ok); end
        tests_run++; if (f_cnt !== 3'd3) begin tests_failed++; $display("FAIL fix_cnt_pushpop: got %0d, expected 3", f_cnt); end
        tick(); m_req = 2'b00; s_addr_ok = 1'b0; #1;
        tests_run++; if (f_data_ok !== 2'b10) begin tests_failed++; $display("FAIL fix_drain0: got %b, expected 10", f_data_ok); end
        tick(); #1;
        tests_run++; if (f_data_ok !== 2'b10) begin tests_failed++; $display("FAIL fix_drain1: got %b, expected 10", f_data_ok); end
        tick(); #1;
        tests_run++; if (f_data_ok !== 2'b01) begin tests_failed++; $display("FAIL fix_drain2: got %b, expected 01", f_data_ok); end
        tick(); clear_inputs(); #1;
        tests_run++; if (f_cnt !== 3'd0) begin tests_failed++; $display("FAIL fix_cnt0: got %0d, expected 0", f_cnt); end
    endtask

    task automatic test_full_blocking();
        m_req = 2'b01; s_addr_ok = 1'b1;
        tick(); tick(); tick(); tick(); #1;
        tests_run++; if (f_cnt !== 3'd4 || f_s_req !== 1'b0) begin tests_failed++; $display("FAIL full_block: got cnt=%0d s_req=%b, expected 4/0", f_cnt, f_s_req); end
        tick(); s_data_ok = 1'b1; #1;
        tests_run++; if (f_s_req !== 1'b0 || f_addr_ok !== 2'b00 || f_data_ok !== 2'b01) begin tests_failed++; $display("FAIL full_same_cycle: got s_req=%b addr_ok=%b data_ok=%b, expected 0/00/01", f_s_req, f_addr_ok, f_data_ok); end
        tick(); s_data_ok = 1'b0; #1;
        tests_run++; if (f_cnt !== 3'd3 || f_s_req !== 1'b1 || f_addr_ok !== 2'b01) begin tests_failed++; $display("FAIL full_next_cycle: got cnt=%0d s_req=%b ok=%b, expected 3/1/01", f_cnt, f_s_req, f_addr_ok); end
        tick(); m_req = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b1;
        tick(); tick(); tick(); tick(); clear_inputs(); #1;
        tests_run++; if (f_cnt !== 3'd0) begin tests_failed++; $display("FAIL full_cnt0: got %0d, expected 0", f_cnt); end
    endtask

    task automatic test_lock();
        m_req = 2'b01; s_addr_ok = 1'b0; #1;
        tests_run++; if (f_s_req !== 1'b1 || f_s_addr !== A0 || f_addr_ok !== 2'b00) begin tests_failed++; $display("FAIL lock_c1: got s_req=%b addr=%h ok=%b, expected 1/%h/00", f_s_req, f_s_addr, f_addr_ok, A0); end
        tick(); m_req = 2'b11; #1;
        tests_run++; if (f_s_addr !== A0) begin tests_failed++; $display("FAIL lock_c2: got %h, expected %h", f_s_addr, A0); end
        tick(); #1;
        tests_run++; if (f_s_addr !== A0) begin tests_failed++; $display("FAIL lock_c3: got %h, expected %h", f_s_addr, A0); end
        tick(); s_addr_ok = 1'b1; #1;
        tests_run++; if (f_addr_ok !== 2'b01 || f_s_addr !== A0) begin tests_failed++; $display("FAIL lock_accept: got ok=%b addr=%h, expected 01/%h", f_addr_ok, f_s_addr, A0); end
        tick(); #1;
        tests_run++; if (f_addr_ok !== 2'b10 || f_s_addr !== A1) begin tests_failed++; $display("FAIL lock_next: got ok=%b addr=%h, expected 10/%h", f_addr_ok, f_s_addr, A1); end
        tick(); m_req = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b1; #1;
        tests_run++; if (f_data_ok !== 2'b01) begin tests_failed++; $display("FAIL lock_resp0: got %b, expected 01", f_data_ok); end
        tick(); #1;
        tests_run++; if (f_data_ok !== 2'b10) begin tests_failed++; $display("FAIL lock_resp1: got %b, expected 10", f_data_ok); end
        tick(); clear_inputs();
    endtask

    task automatic test_proto_err_and_reset();
        s_data_ok = 1'b1; #1;
        tests_run++; if (f_data_ok !== 2'b00 || r_data_ok !== 2'b00 || f_perr !== 1'b0) begin tests_failed++; $display("FAIL perr_no_data_ok: got %b/%b perr=%b, expected 00/00/0", f_data_ok, r_data_ok, f_perr); end
        tick(); s_data_ok = 1'b0; #1;
        tests_run++; if (f_perr !== 1'b1 || r_perr !== 1'b1) begin tests_failed++; $display("FAIL perr_set: got %b/%b, expected 1/1", f_perr, r_perr); end
        tick(); tick(); #1;
        tests_run++; if (f_perr !== 1'b1) begin tests_failed++; $display("FAIL perr_sticky: got %b, expected 1", f_perr); end
        m_req = 2'b01; s_addr_ok = 1'b1;
        tick(); #1;
        tests_run++; if (f_cnt !== 3'd1 || f_addr_ok !== 2'b01) begin tests_failed++; $display("FAIL midrst_pre: got cnt=%0d ok=%b, expected 1/01", f_cnt, f_addr_ok); end
        resetn = 1'b0; #1;
        tests_run++; if (f_cnt !== 3'd0 || f_perr !== 1'b0 || f_s_req !== 1'b0 || f_addr_ok !== 2'b00 || r_cnt !== 3'd0) begin tests_failed++; $display("FAIL midrst_async: got cnt=%0d perr=%b s_req=%b ok=%b rcnt=%0d, expected 0/0/0/00/0", f_cnt, f_perr, f_s_req, f_addr_ok, r_cnt); end
        clear_inputs();
        tick(); resetn = 1'b1;
        tick(); #1;
        tests_run++; if (f_cnt !== 3'd0 || f_perr !== 1'b0) begin tests_failed++; $display("FAIL postrst: got cnt=%0d perr=%b, expected 0/0", f_cnt, f_perr); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_fixed_priority();
        test_full_blocking();
        test_lock();
        test_proto_err_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
